// File: rtl/obi_cpuif_bridge.sv
// rtl/obi_cpuif_bridge.sv - OBI subordinate to cpuif register-block bridge
//
// Purpose:
//   Converts OBI A-channel requests into single-cycle cpuif request strobes.
//   The cpuif returns in-order acknowledgements, which are queued as OBI
//   R-channel responses. An ID FIFO carries each request's aid to its
//   response. An outstanding counter limits accepted-but-unanswered
//   transactions to MAX_OUTSTANDING.
//
// Ports:
//   clk, arst_n                    clock, asynchronous active-low reset
//   req/addr/we/be/wdata/aid, gnt  OBI address channel
//   rvalid/rready/rdata/err/rid    OBI response channel
//   cpuif_req/_is_wr/_addr/_wr_*   cpuif request (combinational from OBI)
//   cpuif_req_stall_wr/_rd         cpuif back-pressure, selected by we
//   cpuif_rd_ack/_err/_data        cpuif read completion
//   cpuif_wr_ack/_err              cpuif write completion
module obi_cpuif_bridge #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int CPUIF_ADDR_WIDTH = 16,
  parameter int ID_WIDTH         = 1,
  parameter int MAX_OUTSTANDING  = 2
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        req,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic                        we,
  input  logic [DATA_WIDTH/8-1:0]     be,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [ID_WIDTH-1:0]         aid,
  output logic                        gnt,
  output logic                        rvalid,
  input  logic                        rready,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        err,
  output logic [ID_WIDTH-1:0]         rid,
  output logic                        cpuif_req,
  output logic                        cpuif_req_is_wr,
  output logic [CPUIF_ADDR_WIDTH-1:0] cpuif_addr,
  output logic [DATA_WIDTH-1:0]       cpuif_wr_data,
  output logic [DATA_WIDTH-1:0]       cpuif_wr_biten,
  input  logic                        cpuif_req_stall_wr,
  input  logic                        cpuif_req_stall_rd,
  input  logic                        cpuif_rd_ack,
  input  logic                        cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0]       cpuif_rd_data,
  input  logic                        cpuif_wr_ack,
  input  logic                        cpuif_wr_err
);

  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(MAX_OUTSTANDING - 1);

  // FIFO depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic                 stall_sel;
  logic                 accept;
  logic                 ack;
  logic                 ack_valid;
  logic [ID_WIDTH-1:0]  ack_id;
  logic [DATA_WIDTH-1:0] ack_data;
  logic                 ack_err;
  logic                 id_empty;
  logic                 id_bypass;
  logic                 id_push;
  logic                 id_pop;
  logic                 rsp_push;
  logic                 rsp_pop;
  logic [CNT_WIDTH-1:0] outstanding;

  logic [ID_WIDTH-1:0]  id_mem [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0] id_wr_ptr;
  logic [PTR_WIDTH-1:0] id_rd_ptr;
  logic [CNT_WIDTH-1:0] id_count;

  logic [DATA_WIDTH-1:0] rsp_data_mem [MAX_OUTSTANDING];
  logic                  rsp_err_mem  [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]   rsp_id_mem   [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0]  rsp_wr_ptr;
  logic [PTR_WIDTH-1:0]  rsp_rd_ptr;
  logic [CNT_WIDTH-1:0]  rsp_count;

  // Request side
  assign stall_sel = we ? cpuif_req_stall_wr : cpuif_req_stall_rd;
  assign gnt       = !stall_sel && (outstanding < MAX_CNT);
  assign accept    = req && gnt;

  assign cpuif_req       = accept;
  assign cpuif_req_is_wr = we;
  assign cpuif_addr      = addr[CPUIF_ADDR_WIDTH-1:0];
  assign cpuif_wr_data   = wdata;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_biten
    assign cpuif_wr_biten[i] = be[i/8];
  end

  if (CPUIF_ADDR_WIDTH < ADDR_WIDTH) begin : g_addr_unused
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_WIDTH-1:CPUIF_ADDR_WIDTH];
  end

  // Completion side. With an empty ID FIFO, a same-cycle ack belongs to the
  // request being accepted now, so its aid bypasses the FIFO entirely.
  assign ack       = cpuif_rd_ack || cpuif_wr_ack;
  assign id_empty  = (id_count == '0);
  assign ack_valid = ack && (!id_empty || accept);
  assign id_bypass = ack_valid && id_empty;
  assign ack_id    = id_empty ? aid : id_mem[id_rd_ptr];
  assign ack_data  = cpuif_rd_ack ? cpuif_rd_data : '0;
  assign ack_err   = cpuif_rd_ack ? cpuif_rd_err : cpuif_wr_err;

  assign id_push  = accept && !id_bypass;
  assign id_pop   = ack_valid && !id_empty;
  assign rsp_push = ack_valid;
  assign rsp_pop  = rvalid && rready;

  // Response side; outputs are masked so they read zero when nothing is queued.
  assign rvalid = (rsp_count != '0);
  assign rdata  = rvalid ? rsp_data_mem[rsp_rd_ptr] : '0;
  assign err    = rvalid ? rsp_err_mem[rsp_rd_ptr]  : 1'b0;
  assign rid    = rvalid ? rsp_id_mem[rsp_rd_ptr]   : '0;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      outstanding <= '0;
      id_wr_ptr   <= '0;
      id_rd_ptr   <= '0;
      id_count    <= '0;
      rsp_wr_ptr  <= '0;
      rsp_rd_ptr  <= '0;
      rsp_count   <= '0;
    end else begin
      outstanding <= outstanding + CNT_WIDTH'(accept) - CNT_WIDTH'(rsp_pop);
      id_count    <= id_count + CNT_WIDTH'(id_push) - CNT_WIDTH'(id_pop);
      rsp_count   <= rsp_count + CNT_WIDTH'(rsp_push) - CNT_WIDTH'(rsp_pop);
      if (id_push)  id_wr_ptr  <= ptr_inc(id_wr_ptr);
      if (id_pop)   id_rd_ptr  <= ptr_inc(id_rd_ptr);
      if (rsp_push) rsp_wr_ptr <= ptr_inc(rsp_wr_ptr);
      if (rsp_pop)  rsp_rd_ptr <= ptr_inc(rsp_rd_ptr);
    end
  end

  // Storage arrays need no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (id_push) id_mem[id_wr_ptr] <= aid;
    if (rsp_push) begin
      rsp_data_mem[rsp_wr_ptr] <= ack_data;
      rsp_err_mem[rsp_wr_ptr]  <= ack_err;
      rsp_id_mem[rsp_wr_ptr]   <= ack_id;
    end
  end

`ifndef SYNTHESIS
  // An ack with nothing outstanding in the ID FIFO and no accept is dropped.
  orphan_ack_check: assert property (@(posedge clk) disable iff (!arst_n)
    !(ack && id_empty && !accept));
`endif

endmodule

// File: tb/tb_obi_cpuif_bridge.sv
// tb/tb_obi_cpuif_bridge.sv - directed self-checking bench for obi_cpuif_bridge
module tb_obi_cpuif_bridge;

  logic        clk;
  logic        arst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [0:0]  aid;
  logic        gnt;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        err;
  logic [0:0]  rid;
  logic        cpuif_req;
  logic        cpuif_req_is_wr;
  logic [15:0] cpuif_addr;
  logic [31:0] cpuif_wr_data;
  logic [31:0] cpuif_wr_biten;
  logic        cpuif_req_stall_wr;
  logic        cpuif_req_stall_rd;
  logic        cpuif_rd_ack;
  logic        cpuif_rd_err;
  logic [31:0] cpuif_rd_data;
  logic        cpuif_wr_ack;
  logic        cpuif_wr_err;

  int n_run;
  int n_fail;

  obi_cpuif_bridge dut (
    .clk(clk), .arst_n(arst_n),
    .req(req), .addr(addr), .we(we), .be(be), .wdata(wdata), .aid(aid),
    .gnt(gnt), .rvalid(rvalid), .rready(rready), .rdata(rdata), .err(err), .rid(rid),
    .cpuif_req(cpuif_req), .cpuif_req_is_wr(cpuif_req_is_wr), .cpuif_addr(cpuif_addr),
    .cpuif_wr_data(cpuif_wr_data), .cpuif_wr_biten(cpuif_wr_biten),
    .cpuif_req_stall_wr(cpuif_req_stall_wr), .cpuif_req_stall_rd(cpuif_req_stall_rd),
    .cpuif_rd_ack(cpuif_rd_ack), .cpuif_rd_err(cpuif_rd_err), .cpuif_rd_data(cpuif_rd_data),
    .cpuif_wr_ack(cpuif_wr_ack), .cpuif_wr_err(cpuif_wr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; aid = '0;
    cpuif_rd_ack = 1'b0; cpuif_rd_err = 1'b0; cpuif_rd_data = '0;
    cpuif_wr_ack = 1'b0; cpuif_wr_err = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rready = 1'b1; cpuif_req_stall_wr = 1'b0; cpuif_req_stall_rd = 1'b0;
    arst_n = 1'b0;
    cyc(); cyc(); smp();
    n_run++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %0h expected 0", rvalid); end
    n_run++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    n_run++; if ({err, rid} !== 2'b00) begin n_fail++; $display("FAIL reset_err_rid: got %b expected 00", {err, rid}); end
    n_run++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL reset_gnt: got %0h expected 1", gnt); end
    n_run++; if (cpuif_req !== 1'b0) begin n_fail++; $display("FAIL reset_cpuif_req: got %0h expected 0", cpuif_req); end
    cyc(); arst_n = 1'b1;
    smp();
    n_run++; if (gnt !== 1'b1 || rvalid !== 1'b0) begin n_fail++; $display("FAIL release_gnt_rvalid: got %b expected 10", {gnt, rvalid}); end
  endtask

  task automatic test_single_read();
    cyc(); req = 1'b1; we = 1'b0; addr = 32'h0000_1004; aid = 1'b1; rready = 1'b0;
    smp();
    n_run++; if (cpuif_req !== 1'b1) begin n_fail++; $display("FAIL rd_cpuif_req: got %0h expected 1", cpuif_req); end
    n_run++; if (cpuif_addr !== 16'h1004) begin n_fail++; $display("FAIL rd_cpuif_addr: got %h expected 1004", cpuif_addr); end
    n_run++; if (cpuif_req_is_wr !== 1'b0) begin n_fail++; $display("FAIL rd_is_wr: got %0h expected 0", cpuif_req_is_wr); end
    cyc(); idle_inputs();
    smp();
    n_run++; if (cpuif_req !== 1'b0) begin n_fail++; $display("FAIL rd_cpuif_req_drop: got %0h expected 0", cpuif_req); end
    cyc();
    cyc(); cpuif_rd_ack = 1'b1; cpuif_rd_data = 32'hDEAD_BEEF;
    smp();
    n_run++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_early: got %0h expected 0", rvalid); end
    cyc(); idle_inputs();
    smp();
    n_run++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid: got %0h expected 1", rvalid); end
    n_run++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rdata: got %h expected deadbeef", rdata); end
    n_run++; if ({err, rid} !== 2'b01) begin n_fail++; $display("FAIL rd_err_rid: got %b expected 01", {err, rid}); end
    cyc(); smp();
    n_run++; if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_hold: got %0h/%h expected 1/deadbeef", rvalid, rdata); end
    cyc(); rready = 1'b1;
    cyc(); smp();
    n_run++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_pop: got %0h expected 0", rvalid); end
  endtask

  task automatic test_write_err();
    cyc(); req = 1'b1; we = 1'b1; be = 4'b0101; wdata = 32'h1234_5678; addr = 32'h20; aid = 1'b0;
    rready = 1'b0; cpuif_wr_ack = 1'b1; cpuif_wr_err = 1'b1;
    smp();
    n_run++; if (cpuif_wr_biten !== 32'h00FF_00FF) begin n_fail++; $display("FAIL wr_biten: got %h expected 00ff00ff", cpuif_wr_biten); end
    n_run++; if ({cpuif_req, cpuif_req_is_wr} !== 2'b11) begin n_fail++; $display("FAIL wr_req: got %b expected 11", {cpuif_req, cpuif_req_is_wr}); end
    n_run++; if (cpuif_wr_data !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_data: got %h expected 12345678", cpuif_wr_data); end
    cyc(); idle_inputs();
    smp();
    n_run++; if ({rvalid, err, rid} !== 3'b110) begin n_fail++; $display("FAIL wr_rsp: got %b expected 110", {rvalid, err, rid}); end
    n_run++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h expected 00000000", rdata); end
    cyc(); rready = 1'b1;
    cyc(); smp();
    n_run++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_pop: got %0h expected 0", rvalid); end
  endtask

  task automatic test_outstanding_limit();
    cyc(); req = 1'b1; we = 1'b0; aid = 1'b0; rready = 1'b0; cpuif_rd_ack = 1'b1; cpuif_rd_data = 32'h11;
    smp();
    n_run++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL lim_gnt0: got %0h expected 1", gnt); end
    cyc(); aid = 1'b1; cpuif_rd_data = 32'h22;
    smp();
    n_run++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL lim_gnt1: got %0h expected 1", gnt); end
    cyc(); aid = 1'b0; cpuif_rd_ack = 1'b0; cpuif_rd_data = 32'h33;
    smp();
    n_run++; if ({gnt, cpuif_req} !== 2'b00) begin n_fail++; $display("FAIL lim_full: got %b expected 00", {gnt, cpuif_req}); end
    n_run++; if (rdata !== 32'h11) begin n_fail++; $display("FAIL lim_head0: got %h expected 00000011", rdata); end
    cyc(); rready = 1'b1;
    smp();
    n_run++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL lim_gnt_hs: got %0h expected 0", gnt); end
    cyc(); rready = 1'b0; cpuif_rd_ack = 1'b1;
    smp();
    n_run++; if ({gnt, cpuif_req} !== 2'b11) begin n_fail++; $display("FAIL lim_third: got %b expected 11", {gnt, cpuif_req}); end
    n_run++; if ({rdata, rid} !== {32'h22, 1'b1}) begin n_fail++; $display("FAIL lim_head1: got %h/%0h expected 00000022/1", rdata, rid); end
    cyc(); idle_inputs(); rready = 1'b1;
    smp();
    n_run++; if ({rdata, rid} !== {32'h22, 1'b1}) begin n_fail++; $display("FAIL lim_head1_hold: got %h/%0h expected 00000022/1", rdata, rid); end
    cyc(); smp();
    n_run++; if ({rvalid, rdata, rid} !== {1'b1, 32'h33, 1'b0}) begin n_fail++; $display("FAIL lim_head2: got %0h/%h/%0h expected 1/00000033/0", rvalid, rdata, rid); end
    cyc(); smp();
    n_run++; if ({rvalid, gnt} !== 2'b01) begin n_fail++; $display("FAIL lim_drain: got %b expected 01", {rvalid, gnt}); end
  endtask

  task automatic test_stall();
    cyc(); cpuif_req_stall_wr = 1'b1; req = 1'b1; we = 1'b0; aid = 1'b1; rready = 1'b1;
    cpuif_rd_ack = 1'b1; cpuif_rd_data = 32'h55;
    smp();
    n_run++; if ({gnt, cpuif_req} !== 2'b11) begin n_fail++; $display("FAIL stall_rd_grant: got %b expected 11", {gnt, cpuif_req}); end
    cyc(); cpuif_rd_ack = 1'b0; we = 1'b1; be = 4'hF; wdata = 32'hCAFE_0001; aid = 1'b0;
    smp();
    n_run++; if ({gnt, cpuif_req} !== 2'b00) begin n_fail++; $display("FAIL stall_wr_block0: got %b expected 00", {gnt, cpuif_req}); end
    n_run++; if ({rvalid, rdata} !== {1'b1, 32'h55}) begin n_fail++; $display("FAIL stall_rd_rsp: got %0h/%h expected 1/00000055", rvalid, rdata); end
    cyc(); smp();
    n_run++; if ({gnt, cpuif_req} !== 2'b00) begin n_fail++; $display("FAIL stall_wr_block1: got %b expected 00", {gnt, cpuif_req}); end
    cyc(); cpuif_req_stall_wr = 1'b0; cpuif_wr_ack = 1'b1;
    smp();
    n_run++; if ({gnt, cpuif_req} !== 2'b11) begin n_fail++; $display("FAIL stall_release: got %b expected 11", {gnt, cpuif_req}); end
    cyc(); idle_inputs();
    smp();
    n_run++; if ({rvalid, err, rdata} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL stall_wr_rsp: got %0h/%0h/%h expected 1/0/00000000", rvalid, err, rdata); end
    cyc(); smp();
    n_run++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %0h expected 0", rvalid); end
  endtask

  task automatic test_id_order();
    rready = 1'b1;
    cyc(); req = 1'b1; we = 1'b0; aid = 1'b0; cpuif_rd_ack = 1'b1; cpuif_rd_data = 32'hA0;
    cyc(); aid = 1'b1; cpuif_rd_ack = 1'b0;
    smp();
    n_run++; if ({rvalid, rid, rdata} !== {2'b10, 32'hA0}) begin n_fail++; $display("FAIL id_first: got %0h/%0h/%h expected 1/0/000000a0", rvalid, rid, rdata); end
    cyc(); req = 1'b0;
    smp();
    n_run++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL id_gap: got %0h expected 0", rvalid); end
    cyc();
    cyc(); req = 1'b1; aid = 1'b0; cpuif_rd_ack = 1'b1; cpuif_rd_data = 32'hB1;
    cyc(); req = 1'b0; cpuif_rd_data = 32'hC0;
    smp();
    n_run++; if ({rvalid, rid, rdata} !== {2'b11, 32'hB1}) begin n_fail++; $display("FAIL id_second: got %0h/%0h/%h expected 1/1/000000b1", rvalid, rid, rdata); end
    cyc(); idle_inputs();
    smp();
    n_run++; if ({rvalid, rid, rdata} !== {2'b10, 32'hC0}) begin n_fail++; $display("FAIL id_third: got %0h/%0h/%h expected 1/0/000000c0", rvalid, rid, rdata); end
    cyc(); smp();
    n_run++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL id_drain: got %0h expected 0", rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data;
    logic [0:0]  exp_id;
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); req = 1'b1; we = 1'b0; aid = 1'(i); cpuif_rd_ack = 1'b1; cpuif_rd_data = 32'h100 + 32'(i);
      smp();
      n_run++; if ({gnt, cpuif_req} !== 2'b11) begin n_fail++; $display("FAIL b2b_grant%0d: got %b expected 11", i, {gnt, cpuif_req}); end
      if (i > 0) begin
        exp_data = 32'h100 + 32'(i - 1);
        exp_id   = 1'(i - 1);
        n_run++; if ({rvalid, rdata, rid} !== {1'b1, exp_data, exp_id}) begin n_fail++; $display("FAIL b2b_rsp%0d: got %0h/%h/%0h expected 1/%h/%0h", i, rvalid, rdata, rid, exp_data, exp_id); end
      end
    end
    cyc(); idle_inputs();
    smp();
    n_run++; if ({rvalid, rdata, rid} !== {1'b1, 32'h103, 1'b1}) begin n_fail++; $display("FAIL b2b_last: got %0h/%h/%0h expected 1/00000103/1", rvalid, rdata, rid); end
    cyc(); smp();
    n_run++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0h expected 0", rvalid); end
  endtask

  task automatic test_reset_midflight();
    rready = 1'b0;
    cyc(); req = 1'b1; we = 1'b0; aid = 1'b1; cpuif_rd_ack = 1'b1; cpuif_rd_data = 32'hE1;
    cyc(); aid = 1'b0; cpuif_rd_data = 32'hE2;
    cyc(); idle_inputs();
    smp();
    n_run++; if ({rvalid, gnt} !== 2'b10) begin n_fail++; $display("FAIL mid_queued: got %b expected 10", {rvalid, gnt}); end
    cyc(); #2 arst_n = 1'b0;
    #1;
    n_run++; if ({rvalid, err, rid} !== 3'b000 || rdata !== 32'h0) begin n_fail++; $display("FAIL mid_async_clear: got %0h/%h expected 0/00000000", rvalid, rdata); end
    cyc(); arst_n = 1'b1; cpuif_req_stall_rd = 1'b1;
    smp();
    n_run++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL mid_stall_sel: got %0h expected 0", gnt); end
    cyc(); cpuif_req_stall_rd = 1'b0; req = 1'b1; aid = 1'b1; cpuif_rd_ack = 1'b1; cpuif_rd_data = 32'h77;
    smp();
    n_run++; if ({gnt, rvalid} !== 2'b10) begin n_fail++; $display("FAIL mid_gnt_after: got %b expected 10", {gnt, rvalid}); end
    cyc(); aid = 1'b0; cpuif_rd_data = 32'h78;
    smp();
    n_run++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL mid_count_cleared: got %0h expected 1", gnt); end
    n_run++; if ({rvalid, rdata, rid} !== {1'b1, 32'h77, 1'b1}) begin n_fail++; $display("FAIL mid_new_rsp: got %0h/%h/%0h expected 1/00000077/1", rvalid, rdata, rid); end
    cyc(); idle_inputs(); rready = 1'b1;
    cyc(); cyc(); smp();
    n_run++; if ({rvalid, gnt} !== 2'b01) begin n_fail++; $display("FAIL mid_drain: got %b expected 01", {rvalid, gnt}); end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_single_read();
    test_write_err();
    test_outstanding_limit();
    test_stall();
    test_id_order();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
